// File: rtl/pc_gen_ras.sv
// -----------------------------------------------------------------------------
// pc_gen_ras - fetch PC generator for the IF stage with a return address stack.
//
// Produces the registered fetch PC (npc). Each cycle it picks the next PC by
// priority: reset, eret, exception, misprediction recovery, branch
// prediction, a previously held (pending) prediction, then sequential
// advance by one fetch group.
//
// A taken prediction that arrives while IF is stalled is parked in a pending
// register and applied on the first unstalled cycle. This avoids redirecting
// through the stall.
//
// Optional feature macro: PC_RAS_EN
//   defined   - a circular return address stack predicts jr $ra targets
//               (bp_call pushes npc+8, bp_ret pops).
//   undefined - no RAS storage, ras_count is 0, bp_call is ignored and
//               bp_ret redirects to bp_target.
//
// Parameters:
//   RESET_ADDR  PC loaded on reset
//   EXC_ADDR    PC loaded on exception
//   FETCH_W     instructions per fetch group (1, 2, 4)
//   RAS_DEPTH   RAS entries (power of 2, >= 2)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 IF stalled, hold npc
//   eret / epc            eret committed, its return address
//   exc_oc                exception taken
//   pred_fail/real_target misprediction resolved, correct PC
//   bp_valid/bp_take/bp_target/bp_call/bp_ret  branch prediction inputs
//   npc                   current fetch PC
//   ras_count             number of valid RAS entries
//   pend_vld              a prediction captured during a stall is pending
// -----------------------------------------------------------------------------
module pc_gen_ras #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
    parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380,
    parameter int unsigned FETCH_W    = 1,
    parameter int unsigned RAS_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           eret,
    input  logic [31:0]                    epc,
    input  logic                           exc_oc,
    input  logic                           pred_fail,
    input  logic [31:0]                    real_target,
    input  logic                           bp_valid,
    input  logic                           bp_take,
    input  logic [31:0]                    bp_target,
    input  logic                           bp_call,
    input  logic                           bp_ret,
    output logic [31:0]                    npc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           pend_vld
);

    localparam logic [31:0] STEP      = 32'(4 * FETCH_W);
    localparam logic [31:0] STEP_MASK = ~(STEP - 32'd1);

    logic [31:0] npc_q, npc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        flush;
    logic        redirect;
    logic [31:0] eff_tgt;

    assign flush    = eret | exc_oc | pred_fail;
    assign redirect = bp_valid & (bp_take | bp_ret);

`ifdef PC_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [31:0]   ras_mem_q [RAS_DEPTH];
    logic [31:0]   ras_mem_d [RAS_DEPTH];
    logic [PW-1:0] ras_top_q, ras_top_d;
    logic [CW-1:0] ras_count_q, ras_count_d;
    logic          ras_nonempty;

    assign ras_nonempty = (ras_count_q != '0);
    // An empty stack falls back to the predictor's own target.
    assign eff_tgt      = (bp_ret && ras_nonempty) ? ras_mem_q[ras_top_q] : bp_target;

    // ras_top_q always indexes the newest entry. Pushing past full simply
    // wraps onto the oldest slot; the count saturates at RAS_DEPTH.
    always_comb begin
        ras_mem_d   = ras_mem_q;
        ras_top_d   = ras_top_q;
        ras_count_d = ras_count_q;
        if (bp_valid && !flush) begin
            if (bp_ret) begin
                if (ras_nonempty) begin
                    ras_top_d   = ras_top_q - PW'(1);
                    ras_count_d = ras_count_q - CW'(1);
                end
            end else if (bp_call) begin
                ras_top_d            = ras_top_q + PW'(1);
                ras_mem_d[ras_top_d] = npc_q + 32'd8;
                if (ras_count_q != CW'(RAS_DEPTH)) begin
                    ras_count_d = ras_count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_top_q   <= '0;
            ras_count_q <= '0;
        end else begin
            ras_top_q   <= ras_top_d;
            ras_count_q <= ras_count_d;
        end
    end

    // Stack contents need no reset; ras_count_q gates every read.
    always_ff @(posedge clk) begin
        ras_mem_q <= ras_mem_d;
    end

    assign ras_count = ras_count_q;
`else
    logic unused_bp_call;

    assign unused_bp_call = bp_call;
    assign eff_tgt        = bp_target;
    assign ras_count      = '0;
`endif

    always_comb begin
        npc_d         = npc_q;
        pend_vld_d    = pend_vld_q;
        pend_target_d = pend_target_q;
        if (flush) begin
            pend_vld_d = 1'b0;
            if (eret) begin
                npc_d = epc;
            end else if (exc_oc) begin
                npc_d = EXC_ADDR;
            end else begin
                npc_d = real_target;
            end
        end else if (redirect) begin
            if (stall) begin
                // A newer prediction replaces an older pending one.
                pend_target_d = eff_tgt;
                pend_vld_d    = 1'b1;
            end else begin
                npc_d      = eff_tgt;
                pend_vld_d = 1'b0;
            end
        end else if (!stall) begin
            if (pend_vld_q) begin
                npc_d      = pend_target_q;
                pend_vld_d = 1'b0;
            end else begin
                // Masking first realigns after an unaligned redirect.
                npc_d = (npc_q & STEP_MASK) + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            npc_q         <= RESET_ADDR;
            pend_vld_q    <= 1'b0;
            pend_target_q <= '0;
        end else begin
            npc_q         <= npc_d;
            pend_vld_q    <= pend_vld_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign npc      = npc_q;
    assign pend_vld = pend_vld_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

    localparam logic [31:0] RST   = 32'hbfc0_0000;
    localparam logic [31:0] EXC   = 32'hbfc0_0380;
    localparam int          DEPTH = 8;
    localparam logic [31:0] STEP  = 32'd4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, eret = 1'b0, exc_oc = 1'b0, pred_fail = 1'b0;
    logic        bp_valid = 1'b0, bp_take = 1'b0, bp_call = 1'b0, bp_ret = 1'b0;
    logic [31:0] epc = '0, real_target = '0, bp_target = '0;

    logic [31:0] npc, npc2;
    logic [3:0]  rc, rc2;
    logic        pv, pv2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_npc;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_ras[$];

    pc_gen_ras #(.FETCH_W(1), .RAS_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .eret(eret), .epc(epc),
        .exc_oc(exc_oc), .pred_fail(pred_fail), .real_target(real_target),
        .bp_valid(bp_valid), .bp_take(bp_take), .bp_target(bp_target),
        .bp_call(bp_call), .bp_ret(bp_ret),
        .npc(npc), .ras_count(rc), .pend_vld(pv)
    );

    pc_gen_ras #(.FETCH_W(2), .RAS_DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset(reset), .stall(stall), .eret(eret), .epc(epc),
        .exc_oc(exc_oc), .pred_fail(pred_fail), .real_target(real_target),
        .bp_valid(bp_valid), .bp_take(bp_take), .bp_target(bp_target),
        .bp_call(bp_call), .bp_ret(bp_ret),
        .npc(npc2), .ras_count(rc2), .pend_vld(pv2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: priority rules applied to the inputs seen at the edge.
    task automatic model_step();
        logic [31:0] eff, old;
        bit          flush, redir, from_ras;
        if (reset) begin
            m_npc      = RST;
            m_pend     = 1'b0;
            m_pend_tgt = '0;
            m_ras.delete();
            return;
        end
        old      = m_npc;
        flush    = eret || exc_oc || pred_fail;
        redir    = bp_valid && (bp_take || bp_ret);
        from_ras = RAS_ON && bp_ret && (m_ras.size() > 0);
        eff      = from_ras ? m_ras[m_ras.size()-1] : bp_target;
        if (flush) begin
            m_pend = 1'b0;
            m_npc  = eret ? epc : (exc_oc ? EXC : real_target);
        end else if (redir) begin
            if (stall) begin
                m_pend     = 1'b1;
                m_pend_tgt = eff;
            end else begin
                m_npc  = eff;
                m_pend = 1'b0;
            end
        end else if (!stall) begin
            if (m_pend) begin
                m_npc  = m_pend_tgt;
                m_pend = 1'b0;
            end else begin
                m_npc = m_npc - (m_npc % STEP) + STEP;
            end
        end
        if (RAS_ON && bp_valid && !flush) begin
            if (bp_ret) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end else if (bp_call) begin
                m_ras.push_back(old + 32'd8);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("npc", npc, m_npc);
        chk("pend_vld", {31'd0, pv}, {31'd0, m_pend});
        chk("ras_count", {28'd0, rc}, 32'(m_ras.size()));
    endtask

    task automatic idle();
        stall = 0; eret = 0; exc_oc = 0; pred_fail = 0;
        bp_valid = 0; bp_take = 0; bp_call = 0; bp_ret = 0;
    endtask

    initial begin
        // reset and free-running sequence
        reset = 1'b1;
        cyc();
        chk("reset_npc", npc, RST);
        chk("reset_npc_fw2", npc2, RST);
        chk("reset_pend_fw2", {31'd0, pv2}, 32'd0);
        chk("reset_cnt_fw2", {28'd0, rc2}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("seq1", npc, 32'hbfc0_0004);
        chk("seq1_fw2", npc2, 32'hbfc0_0008);
        cyc();
        chk("seq2", npc, 32'hbfc0_0008);
        chk("seq2_fw2", npc2, 32'hbfc0_0010);
        cyc();
        chk("seq3", npc, 32'hbfc0_000c);

        // prediction during stall is held until the stall drops
        bp_valid = 1; bp_take = 1; bp_target = 32'hbfc0_0100; stall = 1;
        cyc();
        chk("stall1_npc", npc, 32'hbfc0_000c);
        chk("stall1_pend", {31'd0, pv}, 32'd1);
        bp_valid = 0; bp_take = 0;
        cyc();
        chk("stall2_npc", npc, 32'hbfc0_000c);
        stall = 0;
        cyc();
        chk("pend_apply_npc", npc, 32'hbfc0_0100);
        chk("pend_apply_pend", {31'd0, pv}, 32'd0);

        // exception beats misprediction and prediction
        pred_fail = 1; real_target = 32'h8000_1000; exc_oc = 1;
        bp_valid = 1; bp_take = 1; bp_call = 1; bp_target = 32'h1111_0000;
        cyc();
        chk("exc_npc", npc, EXC);
        chk("exc_cnt", {28'd0, rc}, 32'd0);
        idle();

        // call then return
        pred_fail = 1; real_target = 32'hbfc0_0040;
        cyc();
        idle();
        bp_valid = 1; bp_take = 1; bp_call = 1; bp_target = 32'hbfc0_0200;
        cyc();
        chk("call_npc", npc, 32'hbfc0_0200);
`ifdef PC_RAS_EN
        chk("call_cnt", {28'd0, rc}, 32'd1);
`else
        chk("call_cnt", {28'd0, rc}, 32'd0);
`endif
        bp_call = 0; bp_take = 0; bp_ret = 1; bp_target = 32'h0;
        cyc();
`ifdef PC_RAS_EN
        chk("ret_npc", npc, 32'hbfc0_0048);
`else
        chk("ret_npc", npc, 32'h0000_0000);
`endif
        chk("ret_cnt", {28'd0, rc}, 32'd0);
        idle();

        // overflow: 9 pushes, 9 pops
        for (int i = 0; i < 9; i++) begin
            bp_valid = 1; bp_call = 1;
            cyc();
        end
`ifdef PC_RAS_EN
        chk("ovf_cnt", {28'd0, rc}, 32'd8);
`endif
        idle();
        for (int i = 0; i < 9; i++) begin
            bp_valid = 1; bp_ret = 1; bp_target = 32'h0000_1000 + 32'(i * 16);
            cyc();
        end
        chk("underflow_npc", npc, 32'h0000_1080);
        idle();

        // eret overrides a stalled pending prediction
        bp_valid = 1; bp_take = 1; bp_target = 32'hbfc0_0500; stall = 1;
        cyc();
        chk("pre_eret_pend", {31'd0, pv}, 32'd1);
        bp_valid = 0; bp_take = 0; eret = 1; epc = 32'h8000_0010;
        cyc();
        chk("eret_npc", npc, 32'h8000_0010);
        chk("eret_pend", {31'd0, pv}, 32'd0);
        idle();

        // wrap at top of address space, realign after unaligned redirect
        pred_fail = 1; real_target = 32'hffff_fffc;
        cyc();
        idle();
        cyc();
        chk("wrap_npc", npc, 32'h0000_0000);
        pred_fail = 1; real_target = 32'h0000_0102;
        cyc();
        idle();
        cyc();
        chk("realign_npc", npc, 32'h0000_0104);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 2) == 0);
            eret        = ($urandom_range(0, 39) == 0);
            exc_oc      = ($urandom_range(0, 39) == 0);
            pred_fail   = ($urandom_range(0, 19) == 0);
            bp_valid    = ($urandom_range(0, 1) == 1);
            bp_take     = ($urandom_range(0, 1) == 1);
            bp_call     = ($urandom_range(0, 2) == 0);
            bp_ret      = ($urandom_range(0, 3) == 0);
            epc         = $urandom;
            real_target = $urandom;
            bp_target   = $urandom;
            cyc();
        end
        reset = 0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Fetch PC generator for the IF stage. Successor of the single-issue PC register.
- Parametrised reset and exception vectors, plus a fetch-group width.
- Holds a branch prediction that arrives while the pipeline is stalled, instead of redirecting through the stall.
- Adds a circular return address stack (RAS) that predicts jr $ra targets. Sits between branch prediction/decode, the CP0 exception logic and the I-cache request port.

Parameters:
- RESET_ADDR, 32'hbfc0_0000, PC loaded on reset.
- EXC_ADDR, 32'hbfc0_0380, PC loaded on exception.
- FETCH_W, 1, instructions per fetch group. Legal values: 1, 2, 4. Sequential step = 4*FETCH_W bytes.
- RAS_DEPTH, 8, RAS entries. Power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- stall  in  1  1: IF stalled, hold npc
- eret  in  1  eret committed
- epc  in  32  return address for eret
- exc_oc  in  1  exception taken
- pred_fail  in  1  branch misprediction resolved
- real_target  in  32  correct PC after misprediction
- bp_valid  in  1  prediction valid this cycle
- bp_take  in  1  predicted taken
- bp_target  in  32  predicted target
- bp_call  in  1  predicted instruction is jal/jalr (push)
- bp_ret  in  1  predicted instruction is jr $ra (pop)
- npc  out  32  current fetch PC
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- pend_vld  out  1  a stalled prediction is pending

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset:
  - npc = RESET_ADDR.
  - pend_vld = 0, pend_target = 0.
  - ras_count = 0, RAS top pointer = 0. RAS contents are don't-care.
- All state updates on the posedge. npc is registered; one-cycle latency from any input to npc.
- Priority per cycle, highest first:
  1. reset
  2. eret: npc <= epc
  3. exc_oc: npc <= EXC_ADDR
  4. pred_fail: npc <= real_target
  5. prediction handling
  6. pending apply
  7. sequential advance
- Rules 2-4 ("flush"):
  - Clear pend_vld.
  - Ignore bp_valid that cycle: no RAS push/pop, no pending capture.
  - Take effect regardless of stall.
- Effective predicted target (eff_tgt):
  - if bp_ret and ras_count > 0: RAS top entry;
  - otherwise: bp_target.
- Redirect condition: bp_valid and (bp_take or bp_ret).
- Prediction with redirect, not stalled: npc <= eff_tgt, pend_vld <= 0.
- Prediction with redirect, stalled: npc holds, pend_target <= eff_tgt, pend_vld <= 1. A newer prediction overwrites an older pending one.
- Pending apply: not stalled, pend_vld=1, and no new redirect this cycle → npc <= pend_target, pend_vld <= 0.
- Stall with nothing else active: npc holds.
- Sequential advance: npc <= (npc & ~(4*FETCH_W-1)) + 4*FETCH_W.
  - Realigns to the group boundary after an unaligned redirect.
  - Wraps 32'hffff_fffc → 0 (FETCH_W=1).
- RAS is updated only when bp_valid and no flush, stalled or not:
  - Push (bp_call and not bp_ret): write npc+8 (address after the delay slot) at top+1. top advances mod RAS_DEPTH. ras_count = min(ras_count+1, RAS_DEPTH).
  - Overflow: the oldest entry is overwritten silently.
  - Pop (bp_ret): read top. top decrements mod RAS_DEPTH, ras_count-1.
  - Pop when empty: no pointer change, count stays 0, bp_target used.
  - bp_call and bp_ret together: treated as pop only.
- The RAS is not flushed on pred_fail/exc_oc/eret. Speculative corruption is tolerated.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: RAS as above.
- Undefined:
  - No RAS storage.
  - ras_count tied to 0.
  - bp_call ignored.
  - bp_ret redirects to bp_target.
  - All other behaviour identical.

Test Plan:
- Reset, then 3 free cycles, FETCH_W=1 → npc 0xbfc00000, 04, 08, 0c. With FETCH_W=2 → npc 0xbfc00000, 08, 10.
- bp_valid=1, bp_take=1, bp_target=0xbfc00100, stall=1 for 2 cycles, then stall=0 → npc holds for 2 cycles, pend_vld=1, then npc=0xbfc00100, pend_vld=0.
- pred_fail=1, real_target=0x80001000, same cycle as exc_oc=1 and bp_valid=1 → npc=0xbfc00380, pend_vld=0, ras_count unchanged.
- Call at npc=0xbfc00040 (bp_call, bp_take, bp_target=0xbfc00200), later bp_ret with bp_target=0 → ras_count 1 then 0, npc=0xbfc00048.
- 9 pushes with RAS_DEPTH=8 → ras_count saturates at 8. 8 pops return the 8 newest addresses, newest first. The 9th pop uses bp_target.
- eret=1, epc=0x80000010 while stall=1 and pend_vld=1 → npc=0x80000010, pend_vld=0. With PC_RAS_EN undefined, bp_ret redirects to bp_target.
